// File: rtl/key_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : key_pkg
//  Brief    : Shared source counts, index bases and event-code type for key_scan.
//  Revision : 1.0  initial release
// ============================================================================
package key_pkg;

    localparam int unsigned c_n_btn     = 5;
    localparam int unsigned c_n_sw      = 16;
    localparam int unsigned c_n_src     = 21;
    localparam logic [4:0]  c_btn_base  = 5'd0;
    localparam logic [4:0]  c_sw_base   = 5'd5;

    // [5] = new level, [4:0] = source index
    typedef logic [5:0] evt_code_t;

    function automatic evt_code_t make_evt(input logic lvl, input logic [4:0] idx);
        return {lvl, idx};
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_scan_if.sv
`default_nettype none
// ============================================================================
//  Module   : key_scan_if
//  Brief    : Valid/ready event stream from key_scan to its consumer.
//  Revision : 1.0  initial release
// ============================================================================
interface key_scan_if;
    import key_pkg::*;

    logic      evt_valid;
    logic      evt_ready;
    evt_code_t evt_code;

    modport master (output evt_valid, output evt_code, input evt_ready);
    modport slave  (input evt_valid, input evt_code, output evt_ready);

endinterface
`default_nettype wire

// File: rtl/key_scan_evt_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : evt_fifo
//  Brief    : Registered FIFO with valid/ready pop and a full flag; output is
//             forced to zero while empty.
//  Revision : 1.0  initial release
// ============================================================================
module evt_fifo #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 4
) (
    input  wire              clk,
    input  wire              rst,
    input  wire              i_push,
    input  wire [WIDTH-1:0]  i_data,
    output logic             o_full,
    output logic             o_valid,
    input  wire              i_ready,
    output logic [WIDTH-1:0] o_data
);

    localparam int c_aw = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr;
    logic [c_aw-1:0]  r_rd;
    logic [c_aw:0]    r_cnt;
    logic             w_pop;
    logic             w_push;

    assign o_full  = (r_cnt == (c_aw+1)'(DEPTH));
    assign o_valid = (r_cnt != '0);
    assign o_data  = o_valid ? r_mem[r_rd] : '0;
    assign w_pop   = o_valid && i_ready;
    // A full queue still accepts a push when the head leaves in the same cycle
    assign w_push  = i_push && (!o_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr <= r_wr + c_aw'(1);
            end
            if (w_pop) begin
                r_rd <= r_rd + c_aw'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + (c_aw+1)'(1);
                2'b01:   r_cnt <= r_cnt - (c_aw+1)'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/key_scan.sv
`default_nettype none
// ============================================================================
//  Module   : key_scan
//  Brief    : Synchronizes and debounces 5 buttons and 16 switches, queueing
//             level-change events. KEY_SCAN_SW_EVT_EN enables switch events.
//  Revision : 1.0  initial release
// ============================================================================
module key_scan
    import key_pkg::*;
#(
    parameter int TICK_DIV   = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  wire               clk,
    input  wire               rst,
    input  wire  [4:0]        btn,
    input  wire  [15:0]       sw,
    output logic [4:0]        btn_lvl,
    output logic [15:0]       sw_lvl,
    output logic              evt_ovf,
    key_scan_if.master        evt
);

    localparam int c_pw = $clog2(TICK_DIV);

`ifdef KEY_SCAN_SW_EVT_EN
    localparam logic [c_n_src-1:0] c_evt_mask = '1;
`else
    localparam logic [c_n_src-1:0] c_evt_mask = {{c_n_sw{1'b0}}, {c_n_btn{1'b1}}};
`endif

    logic [c_n_src-1:0] w_raw;
    logic [c_n_src-1:0] r_s1;
    logic [c_n_src-1:0] r_s2;
    logic [c_n_src-1:0] r_h0;
    logic [c_n_src-1:0] r_h1;
    logic [c_n_src-1:0] r_lvl;
    logic [c_n_src-1:0] r_pend;
    logic [c_n_src-1:0] r_dir;
    logic [c_pw-1:0]    r_presc;
    logic               w_tick;
    logic [c_n_src-1:0] w_all1;
    logic [c_n_src-1:0] w_all0;
    logic [c_n_src-1:0] w_chg;
    logic [c_n_src-1:0] w_chg_evt;
    logic [c_n_src-1:0] w_clr;
    logic [4:0]         w_sel_idx;
    logic               w_sel_vld;
    logic               w_full;
    logic               w_pop;
    logic               w_push;
    evt_code_t          w_push_code;

    assign w_raw  = {sw, btn};
    assign w_tick = (r_presc == c_pw'(TICK_DIV - 1));

    // r_h1/r_h0 hold the two previous tick samples; r_s2 is the third at a tick
    assign w_all1    = r_s2 & r_h0 & r_h1;
    assign w_all0    = ~(r_s2 | r_h0 | r_h1);
    assign w_chg     = w_tick ? ((w_all1 & ~r_lvl) | (w_all0 & r_lvl)) : '0;
    assign w_chg_evt = w_chg & c_evt_mask;

    always_comb begin
        w_sel_idx = '0;
        w_sel_vld = 1'b0;
        for (int i = c_n_src - 1; i >= 0; i--) begin
            if (r_pend[i]) begin
                w_sel_vld = 1'b1;
                w_sel_idx = 5'(i);
            end
        end
    end

    assign w_pop       = evt.evt_valid && evt.evt_ready;
    assign w_push      = w_sel_vld && (!w_full || w_pop);
    assign w_clr       = w_push ? (c_n_src'(1) << w_sel_idx) : '0;
    assign w_push_code = make_evt(r_dir[w_sel_idx], w_sel_idx);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1    <= '0;
            r_s2    <= '0;
            r_h0    <= '0;
            r_h1    <= '0;
            r_lvl   <= '0;
            r_pend  <= '0;
            r_dir   <= '0;
            r_presc <= '0;
            evt_ovf <= 1'b0;
        end else begin
            r_s1    <= w_raw;
            r_s2    <= r_s1;
            r_presc <= w_tick ? '0 : r_presc + c_pw'(1);
            if (w_tick) begin
                r_h0 <= r_s2;
                r_h1 <= r_h0;
            end
            r_lvl  <= r_lvl ^ w_chg;
            // A source being pushed this cycle is free to re-arm without loss
            r_pend <= (r_pend & ~w_clr) | w_chg_evt;
            r_dir  <= (r_dir & ~w_chg_evt) | (w_all1 & w_chg_evt);
            if (|(r_pend & ~w_clr & w_chg_evt)) begin
                evt_ovf <= 1'b1;
            end
        end
    end

    assign btn_lvl = r_lvl[c_n_btn-1:0];
    assign sw_lvl  = r_lvl[c_n_src-1:c_n_btn];

    evt_fifo #(
        .WIDTH (6),
        .DEPTH (FIFO_DEPTH)
    ) u_evt_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_push_code),
        .o_full  (w_full),
        .o_valid (evt.evt_valid),
        .i_ready (evt.evt_ready),
        .o_data  (evt.evt_code)
    );

endmodule
`default_nettype wire

// File: doc/key_scan.md
KEY_SCAN -- requirements
Module: key_scan

Interface
REQ-001 SHALL have parameter TICK_DIV, default 4, meaning clk cycles per debounce sample tick (>=2).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning event queue entries (power of two, >=2).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port btn  input  5  raw asynchronous push-buttons.
REQ-006 SHALL have port sw  input  16  raw asynchronous slide switches.
REQ-007 SHALL have port btn_lvl  output  5  debounced button levels.
REQ-008 SHALL have port sw_lvl  output  16  debounced switch levels.
REQ-009 SHALL have port evt_valid  output  1  event queue non-empty.
REQ-010 SHALL have port evt_ready  input  1  consumer accepts head event.
REQ-011 SHALL have port evt_code  output  6  head event: [5]=new level, [4:0]=source index (0-4 btn, 5-20 sw[0..15]).
REQ-012 SHALL have port evt_ovf  output  1  sticky event-lost flag.

Function
REQ-013 SHALL pass every raw input through a 2-flop synchronizer before any use.
REQ-014 SHALL run a prescaler counting 0..TICK_DIV-1 and assert a one-cycle tick when it wraps to 0.
REQ-015 SHALL, on each tick, shift each synchronized source into a per-source 3-sample history.
REQ-016 SHALL update a source's debounced level only when all 3 samples agree and differ from the current level; agreement becomes visible on the output the cycle after the tick.
REQ-017 SHALL, on each debounced level change, set that source's pending bit and record the new level as the pending direction.
REQ-018 SHALL, if a source changes while its pending bit is already set, overwrite the direction, keep pending set, and set evt_ovf.
REQ-019 SHALL each cycle push at most one event: the lowest-index pending source, clearing its pending bit in the same cycle.
REQ-020 SHALL allow a push when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
REQ-021 SHALL pop on evt_valid && evt_ready; evt_code SHALL stay stable while evt_valid && !evt_ready.
REQ-022 SHALL give push-to-evt_valid latency of 1 cycle (registered FIFO, no fall-through).
REQ-023 SHALL, when the FIFO is empty and a push and a pop request coincide, perform only the push.
REQ-024 SHALL keep pending bits set while the FIFO is full; no event SHALL be silently dropped except through REQ-018.

Reset
REQ-025 SHALL, on rst, clear synchronizers, histories, prescaler, pending bits, FIFO pointers, and evt_ovf.
REQ-026 SHALL drive btn_lvl=0, sw_lvl=0, evt_valid=0, evt_code=0, and evt_ovf=0 during and after reset until new data arrives.
REQ-027 SHALL, when rst is asserted mid-operation, discard queued events within the same cycle.

Configuration
REQ-028 SHALL, with KEY_SCAN_SW_EVT_EN defined, generate events for switch sources 5-20.
REQ-029 SHALL, without KEY_SCAN_SW_EVT_EN, still debounce switches to sw_lvl but never set switch pending bits; only button events are queued.

Structure
REQ-030 SHALL place the source-count constants (5 btn, 16 sw, 21 total), the 6-bit event code typedef, and the source index base constants in shared package key_pkg.
REQ-031 SHALL implement the event queue as a sub-module evt_fifo (width 6, depth FIFO_DEPTH, valid/ready pop, full flag).

Verification
REQ-032 SHALL verify: after rst, btn=5'b00001 held for 20 cycles -> btn_lvl[0]=1 and exactly one event, evt_code=6'b100000.
REQ-033 SHALL verify: btn[2] glitch high for 5 cycles (< 3 ticks) -> btn_lvl unchanged, evt_valid stays 0.
REQ-034 SHALL verify: btn[1] and btn[3] rise in the same cycle -> events 6'b100001, then 6'b100011, in that order.
REQ-035 SHALL verify: evt_ready=0 and 6 button edges -> 4 events queued, 2 pending; after draining, all 6 are delivered in order and evt_ovf=0.
REQ-036 SHALL verify: sw[0] toggles 0->1->0 while pending is blocked by a full FIFO -> evt_ovf=1 and a single event 6'b000101 is delivered with the macro defined; with the macro undefined, no sw event is delivered and sw_lvl still tracks.
REQ-037 SHALL verify: rst asserted with 3 events queued -> evt_valid=0 the next cycle and evt_ovf=0.
